display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexing scheduler for the multi-digit 7-segment display path. It steps a digit-select through DIGITS BCD digits at a programmable scan rate and inserts a blanking gap between digits to suppress ghosting. It presents one 4-bit digit per slot together with a one-hot digit enable, and can optionally blank leading zeros. It sits between the counter's BCD digit outputs and the segment decoder / digit drivers.

Parameters:
DIGITS, 3, number of digits scanned (2..8); digit 0 is the least significant.
DIV_W, 16, width of the scan-period register.
BLANK_CYC, 2, length in clk cycles of the blanking gap between digits (0 = no gap).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  scan enable; 0 forces IDLE with the display dark.
div_val  input  DIV_W  per-digit on-time minus 1, in clk cycles.
lz_blank  input  1  1 = blank leading zeros.
digits_in  input  4*DIGITS  BCD digits; digit i is at bits [4i+3:4i].
sel  output  SW  current digit index, where SW = max(1, clog2(DIGITS)).
dig_en  output  DIGITS  one-hot active-high digit driver enable; all zero when dark.
data_out  output  4  BCD value of the current digit.
blank  output  1  1 whenever dig_en == 0.
frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- All outputs are registered.
- Reset values, applied on any clk edge with rst=1 (rst overrides en): state=IDLE, sel=0, dig_en=0, data_out=0, blank=1, frame_done=0, prescaler=0, snapshot=0.
- States: IDLE, SHOW, GAP.
- IDLE:
  - Outputs are at their reset values.
  - When en=1 at an edge: go to SHOW with sel=0 and cnt=0, capture digits_in into the snapshot, and latch div_val into div_lat.
  - frame_done is not pulsed on this initial start.
- SHOW:
  - data_out = snapshot digit[sel]; dig_en = one-hot(sel) unless that digit is blanked; blank = ~|dig_en.
  - cnt increments each cycle. When cnt==div_lat: go to GAP if BLANK_CYC>0, otherwise advance directly.
  - The SHOW slot therefore lasts exactly div_lat+1 cycles; div_val=0 gives a 1-cycle slot.
- GAP:
  - dig_en=0, blank=1; sel and data_out hold.
  - After BLANK_CYC cycles: advance.
- Advance:
  - If sel < DIGITS-1: sel+1.
  - Otherwise: sel=0, recapture the snapshot from digits_in, and assert frame_done=1 for the first cycle of the new digit-0 slot.
  - On every advance: cnt=0, div_lat reloaded from div_val, state SHOW.
- Frame period = DIGITS*(div_lat+1+BLANK_CYC) cycles.
- Snapshot: the whole digits_in vector is captured only at frame start, so a frame is never torn. Changes to digits_in mid-frame appear in the next frame.
- Leading-zero blanking: with lz_blank=1, digit i (i>0) is blanked when snapshot digits i..DIGITS-1 are all zero. Digit 0 is never blanked. A blanked slot keeps its normal timing, with dig_en=0 and blank=1.
- en=0 in any state: at the next edge go to IDLE with reset-value outputs. Re-enabling always restarts at digit 0.
- div_val changes take effect only at the next slot boundary.

Test Plan:
(DIGITS=3, BLANK_CYC=2, div_val=3 unless stated)
1. rst=1 for 2 cycles with en=1 -> sel=0, dig_en=000, data_out=0, blank=1, frame_done=0 throughout.
2. digits_in=12'h321, lz_blank=0, en=1 -> the following pattern repeats with an 18-cycle period, and frame_done is high only on the first 001 cycle of each later frame:
   - dig_en=001 with data_out=1 for 4 cycles, then 000 for 2;
   - 010 with data_out=2 for 4, then 000 for 2;
   - 100 with data_out=3 for 4, then 000 for 2.
3. lz_blank=1:
   - digits_in=12'h005 -> the digit-2 and digit-1 slots have dig_en=000, blank=1; the digit-0 slot has 001 with data_out=5.
   - digits_in=12'h000 -> digit 0 still shows 0.
   - digits_in=12'h305 -> all three digits are shown.
4. digits_in switches from 12'h321 to 12'h654 during the digit-0 slot -> slots 1 and 2 still show 2 and 3; the next frame shows 4, 5, 6.
5. en dropped mid-SHOW of digit 1 -> next cycle dig_en=000, sel=0, blank=1. Re-assert en -> the digit-0 slot starts on the next cycle with no frame_done.
6. div_val=0 with BLANK_CYC=0 -> dig_en rotates 001→010→100 every cycle and frame_done pulses every 3 cycles. Then rst asserted with en=1 -> reset values at the next edge.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Bus between the BCD digit source and the display scan controller.
// master drives the digits and scan settings; slave is the scan controller.
interface display_scan_ctrl_if #(
  parameter int DIGITS = 3,
  parameter int DIV_W  = 16,
  parameter int SW     = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1
) ();

  logic                  en;
  logic [DIV_W-1:0]      div_val;
  logic                  lz_blank;
  logic [4*DIGITS-1:0]   digits_in;
  logic [SW-1:0]         sel;
  logic [DIGITS-1:0]     dig_en;
  logic [3:0]            data_out;
  logic                  blank;
  logic                  frame_done;

  modport master (
    output en, div_val, lz_blank, digits_in,
    input  sel, dig_en, data_out, blank, frame_done
  );

  modport slave (
    input  en, div_val, lz_blank, digits_in,
    output sel, dig_en, data_out, blank, frame_done
  );

endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment digit scanner: steps through the BCD digits with
// a programmable on-time, a blanking gap between digits and leading-zero blanking.
module display_scan_ctrl #(
  parameter int DIGITS    = 3,
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_ctrl_if.slave   bus
);

  localparam int SW = ($clog2(DIGITS) > 1) ? $clog2(DIGITS) : 1;
  localparam int GW = ($clog2(BLANK_CYC) > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [GW-1:0] GLAST = GW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [SW-1:0] SLAST = SW'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]          state, nxt_state;
  logic [SW-1:0]       nxt_sel;
  logic [DIV_W-1:0]    cnt, nxt_cnt;
  logic [DIV_W-1:0]    div_lat, nxt_lat;
  logic [GW-1:0]       gcnt, nxt_gcnt;
  logic [4*DIGITS-1:0] snapshot, nxt_snap;
  logic                nxt_fd;
  logic                advance;
  logic [3:0]          nxt_digit;
  logic [DIGITS-1:0]   nxt_onehot;
  logic                any_nz;
  logic                hide;
  logic [DIGITS-1:0]   nxt_dig_en;

  // Next-state values are computed first so the registered outputs line up
  // with the slot they describe rather than lagging by one cycle.
  always_comb begin
    nxt_state = state;
    nxt_sel   = bus.sel;
    nxt_cnt   = cnt + DIV_W'(1);
    nxt_gcnt  = gcnt + GW'(1);
    nxt_lat   = div_lat;
    nxt_snap  = snapshot;
    nxt_fd    = 1'b0;
    advance   = 1'b0;

    case (state)
      IDLE: begin
        nxt_state = SHOW;
        nxt_sel   = '0;
        nxt_cnt   = '0;
        nxt_snap  = bus.digits_in;
        nxt_lat   = bus.div_val;
      end
      SHOW: begin
        if (cnt == div_lat) begin
          if (BLANK_CYC > 0) begin
            nxt_state = GAP;
            nxt_gcnt  = '0;
          end else begin
            advance = 1'b1;
          end
        end
      end
      GAP: begin
        if (gcnt == GLAST) advance = 1'b1;
      end
      default: nxt_state = IDLE;
    endcase

    if (advance) begin
      nxt_state = SHOW;
      nxt_cnt   = '0;
      nxt_lat   = bus.div_val;
      if (bus.sel == SLAST) begin
        nxt_sel  = '0;
        nxt_snap = bus.digits_in;
        nxt_fd   = 1'b1;
      end else begin
        nxt_sel = bus.sel + SW'(1);
      end
    end

    if (!bus.en) begin
      nxt_state = IDLE;
      nxt_sel   = '0;
      nxt_cnt   = '0;
      nxt_fd    = 1'b0;
    end
  end

  // A digit above 0 is hidden when it and every more significant digit is zero.
  always_comb begin
    nxt_digit  = 4'd0;
    nxt_onehot = '0;
    any_nz     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (SW'(i) == nxt_sel) begin
        nxt_digit     = nxt_snap[4*i +: 4];
        nxt_onehot[i] = 1'b1;
      end
      if (i >= int'(nxt_sel) && nxt_snap[4*i +: 4] != 4'd0) any_nz = 1'b1;
    end
    hide       = bus.lz_blank && (nxt_sel != '0) && !any_nz;
    nxt_dig_en = (nxt_state == SHOW && !hide) ? nxt_onehot : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      div_lat        <= '0;
      gcnt           <= '0;
      snapshot       <= '0;
      bus.sel        <= '0;
      bus.dig_en     <= '0;
      bus.data_out   <= 4'd0;
      bus.blank      <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= nxt_state;
      cnt            <= nxt_cnt;
      div_lat        <= nxt_lat;
      gcnt           <= nxt_gcnt;
      snapshot       <= nxt_snap;
      bus.sel        <= nxt_sel;
      bus.dig_en     <= nxt_dig_en;
      bus.data_out   <= (nxt_state == IDLE) ? 4'd0 : nxt_digit;
      bus.blank      <= ~|nxt_dig_en;
      bus.frame_done <= nxt_fd;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: one instance with a 2-cycle gap and
// one with no gap for the fastest scan rate.
module tb_display_scan_ctrl;

  logic clk;
  logic rst_a, rst_b;
  int   compared;
  int   mismatched;

  display_scan_ctrl_if #(.DIGITS(3), .DIV_W(16)) bus_a ();
  display_scan_ctrl_if #(.DIGITS(3), .DIV_W(16)) bus_b ();

  display_scan_ctrl #(.DIGITS(3), .DIV_W(16), .BLANK_CYC(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  display_scan_ctrl #(.DIGITS(3), .DIV_W(16), .BLANK_CYC(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkA(input string tag, input logic [1:0] s, input logic [2:0] de,
                        input logic [3:0] d, input logic bl, input logic fd);
    checkOutput({tag, " sel"},        32'(bus_a.sel),        32'(s));
    checkOutput({tag, " dig_en"},     32'(bus_a.dig_en),     32'(de));
    checkOutput({tag, " data_out"},   32'(bus_a.data_out),   32'(d));
    checkOutput({tag, " blank"},      32'(bus_a.blank),      32'(bl));
    checkOutput({tag, " frame_done"}, 32'(bus_a.frame_done), 32'(fd));
  endtask

  // Each digit slot is 4 on-cycles (div_val=3) followed by 2 gap cycles.
  task automatic checkFrame(input string name, input logic [11:0] digs, input logic [2:0] mask,
                            input bit fdFirst, input int ncyc, input int swapAt,
                            input logic [11:0] newDigs);
    for (int k = 0; k < ncyc; k++) begin
      int         slot;
      bit         show;
      logic [2:0] expEn;
      logic [3:0] expData;
      applyStimulus();
      slot    = k / 6;
      show    = mask[slot] && ((k % 6) < 4);
      expEn   = show ? (3'b001 << slot) : 3'b000;
      expData = digs[4*slot +: 4];
      checkA($sformatf("%s k%0d", name, k), 2'(slot), expEn, expData, !show,
             (k == 0) && fdFirst);
      if (k == swapAt) bus_a.digits_in = newDigs;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.en = 1'b1;  bus_a.div_val = 16'd3; bus_a.lz_blank = 1'b0; bus_a.digits_in = 12'h321;
    bus_b.en = 1'b0;  bus_b.div_val = 16'd0; bus_b.lz_blank = 1'b0; bus_b.digits_in = 12'h321;

    // Reset wins over en
    applyStimulus();
    checkA("reset0", 2'd0, 3'b000, 4'd0, 1'b1, 1'b0);
    applyStimulus();
    checkA("reset1", 2'd0, 3'b000, 4'd0, 1'b1, 1'b0);
    rst_a = 1'b0;

    // Basic scan, first frame has no frame_done
    checkFrame("scan1", 12'h321, 3'b111, 0, 18, -1, 12'h000);
    checkFrame("scan2", 12'h321, 3'b111, 1, 18, -1, 12'h000);

    // Leading-zero blanking
    bus_a.lz_blank  = 1'b1;
    bus_a.digits_in = 12'h005;
    checkFrame("lz005", 12'h005, 3'b001, 1, 18, -1, 12'h000);
    bus_a.digits_in = 12'h000;
    checkFrame("lz000", 12'h000, 3'b001, 1, 18, -1, 12'h000);
    bus_a.digits_in = 12'h305;
    checkFrame("lz305", 12'h305, 3'b111, 1, 18, -1, 12'h000);

    // Mid-frame change appears only in the next frame
    bus_a.lz_blank  = 1'b0;
    bus_a.digits_in = 12'h321;
    checkFrame("tear321", 12'h321, 3'b111, 1, 18, 0, 12'h654);
    checkFrame("tear654", 12'h654, 3'b111, 1, 18, -1, 12'h000);

    // Drop en during digit 1 on-time, then restart at digit 0
    checkFrame("pre_dis", 12'h654, 3'b111, 1, 8, -1, 12'h000);
    bus_a.en = 1'b0;
    applyStimulus();
    checkA("dis0", 2'd0, 3'b000, 4'd0, 1'b1, 1'b0);
    applyStimulus();
    checkA("dis1", 2'd0, 3'b000, 4'd0, 1'b1, 1'b0);
    bus_a.en = 1'b1;
    checkFrame("reen", 12'h654, 3'b111, 0, 18, -1, 12'h000);

    // No gap, 1-cycle slots
    rst_b    = 1'b0;
    bus_b.en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      int slot;
      applyStimulus();
      slot = k % 3;
      checkOutput($sformatf("fast k%0d sel", k),        32'(bus_b.sel),        32'(slot));
      checkOutput($sformatf("fast k%0d dig_en", k),     32'(bus_b.dig_en),     32'(3'b001 << slot));
      checkOutput($sformatf("fast k%0d data_out", k),   32'(bus_b.data_out),   32'(slot + 1));
      checkOutput($sformatf("fast k%0d blank", k),      32'(bus_b.blank),      32'd0);
      checkOutput($sformatf("fast k%0d frame_done", k), 32'(bus_b.frame_done), 32'((k >= 3) && (slot == 0)));
    end
    rst_b = 1'b1;
    applyStimulus();
    checkOutput("fast_rst sel",        32'(bus_b.sel),        32'd0);
    checkOutput("fast_rst dig_en",     32'(bus_b.dig_en),     32'd0);
    checkOutput("fast_rst data_out",   32'(bus_b.data_out),   32'd0);
    checkOutput("fast_rst blank",      32'(bus_b.blank),      32'd1);
    checkOutput("fast_rst frame_done", 32'(bus_b.frame_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
